// File: rtl/fetch_queue.sv
// Fetch stage: samples the PC, keeps one instruction read outstanding and buffers responses in order.
// Optional FETCH_BYPASS_EN: an empty queue forwards a response to the decoder in the same cycle.
module fetch_queue #(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               CLK,
  input  logic               areset,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_adv,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  input  logic               out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state_q, state_d;
  logic               disc_q, disc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  addr_mem  [DEPTH];

  logic               resp;
  logic               byp_vld;
  logic               byp_take;
  logic               push;
  logic               pop;
  logic               start;
  logic [CNT_W-1:0]   cnt_after;

  // Queue bookkeeping; flush overrides any push or pop in the same cycle.
  always_comb begin
    resp = (state_q == WAIT) && mem_rvalid;
`ifdef FETCH_BYPASS_EN
    byp_vld = resp && !disc_q && !flush && (cnt_q == '0);
`else
    byp_vld = 1'b0;
`endif
    byp_take  = byp_vld && out_ready;
    push      = resp && !disc_q && !flush && !byp_take;
    pop       = (cnt_q != '0) && out_ready && !flush;
    cnt_after = cnt_q + CNT_W'(push) - CNT_W'(pop);
    cnt_d     = flush ? '0 : cnt_after;
    rd_d      = flush ? '0 : rd_q + PTR_W'(pop);
    wr_d      = flush ? '0 : wr_q + PTR_W'(push);
  end

  // Fetch FSM: a new fetch starts only while the queue still has an unreserved slot.
  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    addr_d  = addr_q;
    start   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: start = !flush && (cnt_q < DEPTH_C);
      REQ: begin
        mem_req = 1'b1;
        if (flush)   disc_d  = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          disc_d  = 1'b0;
          state_d = IDLE;
          start   = !flush && (cnt_after < DEPTH_C);
        end else if (flush) begin
          disc_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = REQ;
      addr_d  = pc_addr;
    end
    pc_adv = start && !areset;
  end

  always_ff @(posedge CLK) begin
    if (areset) begin
      state_q <= IDLE;
      disc_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !areset) begin
      instr_mem[wr_q] <= mem_rdata;
      addr_mem[wr_q]  <= addr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!areset) begin
      assert (!(push && (cnt_q == DEPTH_C)));
    end
  end

  assign mem_addr = addr_q;

  // Head of queue, or the live response when it bypasses an empty queue.
  always_comb begin
    out_valid = (cnt_q != '0);
    out_instr = out_valid ? instr_mem[rd_q] : '0;
    out_addr  = out_valid ? addr_mem[rd_q]  : '0;
    if (byp_vld) begin
      out_valid = 1'b1;
      out_instr = mem_rdata;
      out_addr  = addr_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Samples the PC address, issues a single-outstanding read to instruction memory, and buffers the returned instructions with their addresses in a small in-order queue for the decoder.
- Provides redirect flushing for branches/jumps, asserted in the same cycle the PC is loaded.

Parameters:
DEPTH, 2, queue entries (power of two, 2..8)
ADDR_W, 8, instruction address width
INSTR_W, 16, instruction word width

Ports:
CLK  input  1  clock
areset  input  1  reset, synchronous, active-high
pc_addr  input  ADDR_W  current PC value (fetch address source)
pc_adv  output  1  pulse: pc_addr captured, PC may advance
flush  input  1  redirect; discard queue and in-flight fetch
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  memory read address
mem_gnt  input  1  memory accepted request this cycle
mem_rvalid  input  1  read data valid (in order, >=1 cycle after gnt)
mem_rdata  input  INSTR_W  read data
out_valid  output  1  head entry valid
out_instr  output  INSTR_W  head instruction
out_addr  output  ADDR_W  head instruction address
out_ready  input  1  decoder accepts head

Behaviour:
- Reset: areset, synchronous, active-high; clock CLK. All outputs 0; state IDLE; queue empty; discard flag 0. Reset mid-request abandons it; a later mem_rvalid for it is ignored while in IDLE.
- Credit: space = DEPTH - count - (state==WAIT ? 1 : 0). A fetch may start only when space > 0.
- FSM states IDLE, REQ, WAIT.
- IDLE:
  - If space>0 and !flush: capture pc_addr into mem_addr, pulse pc_adv for 1 cycle, go to REQ.
  - mem_rvalid in IDLE is ignored.
- REQ:
  - mem_req=1; mem_addr held stable until mem_gnt.
  - On mem_gnt: go to WAIT.
  - flush in REQ: request is not retracted; discard flag set; transition to WAIT on gnt as normal.
- WAIT:
  - On mem_rvalid: if discard=0 and flush=0, push {mem_addr, mem_rdata}; clear discard.
  - After the response, if space>0 (counted after push/pop this cycle) and !flush: capture pc_addr, pulse pc_adv, go to REQ in the same edge (back-to-back fetch, 1 idle cycle per instruction minimum latency gnt->rvalid excluded).
  - Otherwise go to IDLE.
  - flush in WAIT without rvalid: set discard.
- Queue: circular buffer, rd/wr pointers with wrap at DEPTH, count 0..DEPTH.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged.
  - Push never occurs when full (credit guarantees it); an assertion flags violation.
- Outputs:
  - out_valid = count!=0; out_instr/out_addr = head entry, registered storage.
  - Latency mem_rvalid -> out_valid: 1 cycle.
- flush:
  - Clears the queue (count=0, pointers to 0) at the next edge.
  - Overrides a same-cycle push and pop; pop is not counted.
  - out_valid is 0 the cycle after flush.
  - No pc_adv in a flush cycle; the next capture uses the redirected pc_addr one cycle later.
- mem_addr holds its last value when idle; mem_req=0 outside REQ.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when queue empty, state WAIT, mem_rvalid=1, discard=0, !flush, the response drives out_valid/out_instr/out_addr combinationally in that cycle. If out_ready=1 it is consumed without a push; otherwise it is pushed normally. Latency rvalid -> out_valid is 0.
- Undefined: no bypass; always 1 cycle through the queue.

Test Plan:
- Reset, pc_addr=8'h00, mem_gnt=1, rvalid 1 cycle after gnt, rdata=16'hA001, out_ready=1 -> pc_adv pulse, mem_req with addr 00, out_valid with instr A001/addr 00 one cycle after rvalid.
- out_ready=0, DEPTH=2, continuous gnt/rvalid -> exactly 2 entries queued, then mem_req stays 0 and pc_adv stays 0; raising out_ready resumes fetching with no lost or duplicated instruction.
- flush asserted while state WAIT (rdata=16'hDEAD pending) -> DEAD never appears on out_instr; next fetch addr = new pc_addr (e.g. 8'h40).
- flush while REQ with mem_gnt held low 3 cycles -> mem_req and mem_addr remain stable until gnt; the response is discarded; queue empty after flush.
- Simultaneous push and pop with count=1 -> count stays 1, order preserved (addresses 05 then 06 delivered in sequence); pointer wrap exercised over 10 instructions.
- areset asserted while WAIT, then rvalid arrives -> ignored; all outputs 0; first post-reset fetch uses the current pc_addr.
